// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and its bit shifter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  // Width of a counter that must reach clks-1; never narrower than one bit.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes plus serial/status outputs of the UART transmit arbiter.
interface uart_tx_arbiter_if;

  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_last;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_last;
  logic       req1_ready;
  logic       txd;
  logic       busy;
  logic       owner;

  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    input  req0_ready, req1_ready, txd, busy, owner
  );

  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    output req0_ready, req1_ready, txd, busy, owner
  );

endinterface

// File: rtl/uart_tx_shifter.sv
// Serialises one byte as start bit, 8 data bits LSB first and stop bit.
// A start request is honoured only while IDLE; done marks the last STOP cycle.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  tx_state_e      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           txd_n;
  logic           last_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      txd     <= txd_n;
    end
  end

  assign last_tick = (cnt == LAST_TICK);

  // txd_n is the line level for the state being entered, so txd stays registered.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    txd_n     = txd;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (start) begin
          state_n   = START;
          cnt_n     = '0;
          bit_idx_n = '0;
          shreg_n   = data;
          txd_n     = 1'b0;
        end
      end

      START: begin
        if (last_tick) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
          txd_n     = shreg[0];
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        if (last_tick) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            txd_n     = shreg[1];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STOP: begin
        txd_n = 1'b1;
        if (last_tick) begin
          state_n = IDLE;
          cnt_n   = '0;
          done    = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin between packets, with the
// granted requester holding the line until it sends a byte marked last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  logic       in_flight;
  logic       lock;
  logic       ptr;
  logic       owner_q;
  logic       gnt_valid;
  logic       gnt_id;
  logic       gnt_last;
  logic [7:0] gnt_data;
  logic       accept;
  logic       frame_done;
  logic       txd_w;

  // While a packet lock is held only the owner is looked at; otherwise ptr breaks ties.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ptr;
    if (lock) begin
      gnt_id    = owner_q;
      gnt_valid = owner_q ? bus.req1_valid : bus.req0_valid;
    end else if (bus.req0_valid && bus.req1_valid) begin
      gnt_id    = ptr;
      gnt_valid = 1'b1;
    end else if (bus.req0_valid) begin
      gnt_id    = 1'b0;
      gnt_valid = 1'b1;
    end else if (bus.req1_valid) begin
      gnt_id    = 1'b1;
      gnt_valid = 1'b1;
    end
    gnt_last = gnt_id ? bus.req1_last : bus.req0_last;
    gnt_data = gnt_id ? bus.req1_data : bus.req0_data;
  end

  assign accept = !in_flight && gnt_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= 1'b0;
      lock      <= 1'b0;
      ptr       <= 1'b0;
      owner_q   <= 1'b0;
    end else if (accept) begin
      in_flight <= 1'b1;
      owner_q   <= gnt_id;
      lock      <= !gnt_last;
      if (gnt_last) begin
        ptr <= !gnt_id;
      end
    end else if (frame_done) begin
      in_flight <= 1'b0;
    end
  end

  uart_tx_shifter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .data  (gnt_data),
    .txd   (txd_w),
    .done  (frame_done)
  );

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;
  assign bus.txd        = txd_w;
  assign bus.busy       = in_flight || lock;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at 4 clocks per bit: vector table of
// packets with expected grant/frame, plus mid-frame reset and locked-idle sequences.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  typedef struct {
    bit         do_reset;
    bit         v0;
    logic [7:0] d0;
    bit         l0;
    bit         v1;
    logic [7:0] d1;
    bit         l1;
    bit         exp_owner;
    logic [7:0] exp_data;
    bit         exp_busy_after;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rs, input bit v0, input logic [7:0] d0, input bit l0,
                              input bit v1, input logic [7:0] d1, input bit l1,
                              input bit eo, input logic [7:0] ed, input bit eb);
    vec_t v;
    v.do_reset = rs; v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.exp_owner = eo; v.exp_data = ed; v.exp_busy_after = eb;
    return v;
  endfunction

  // Leaves the bench on a negedge with rst just released.
  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_state", {bus.txd, bus.busy, bus.owner, bus.req0_ready, bus.req1_ready},
                 5'b10000);
    rst = 1'b0;
  endtask

  // Called on a negedge; returns on the first idle negedge after the frame.
  task automatic apply_stimulus(input vec_t v, input int idx, output int waited);
    logic        got;
    logic        r0;
    logic        r1;
    logic [39:0] s;
    logic        own;
    int          stray;
    int          busy_low;
    logic        eb;
    if (v.do_reset) do_reset();
    bus.req0_valid = v.v0; bus.req0_data = v.d0; bus.req0_last = v.l0;
    bus.req1_valid = v.v1; bus.req1_data = v.d1; bus.req1_last = v.l1;
    waited = 0; got = 1'b0; r0 = 1'b0; r1 = 1'b0;
    while (waited < 60) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        got = 1'b1; r0 = bus.req0_ready; r1 = bus.req1_ready;
        break;
      end
      @(negedge clk);
      waited++;
    end
    check_output($sformatf("v%0d_grant", idx), {got, r1, r0}, {1'b1, v.exp_owner, !v.exp_owner});
    if (!got) return;
    stray = 0; busy_low = 0; own = 1'b0; s = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        own = bus.owner;
        if (v.exp_owner) bus.req1_valid = 1'b0;
        else             bus.req0_valid = 1'b0;
      end else if (bus.req0_ready || bus.req1_ready) begin
        stray++;
      end
      if (!bus.busy) busy_low++;
      s[i] = bus.txd;
    end
    for (int k = 0; k < 10; k++) begin
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : v.exp_data[k-1];
      check_output($sformatf("v%0d_bit%0d", idx, k), s[4*k+3 -: 4], {4{eb}});
    end
    check_output($sformatf("v%0d_owner", idx), own, v.exp_owner);
    check_output($sformatf("v%0d_no_ready_in_frame", idx), stray, 0);
    check_output($sformatf("v%0d_busy_in_frame", idx), busy_low, 0);
    @(negedge clk);
    check_output($sformatf("v%0d_after", idx), {bus.busy, bus.txd}, {v.exp_busy_after, 1'b1});
  endtask

  initial begin
    vec_t vecs[12];
    vec_t v;
    int   w;
    int   bad;
    bus.req0_data = '0; bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
    bus.req1_data = '0; bus.req1_valid = 1'b0; bus.req1_last = 1'b0;

    //              rst v0 d0     l0 v1 d1     l1 own data   busy
    vecs[0]  = mk(1, 1, 8'hA5, 1, 0, 8'h00, 0, 0, 8'hA5, 0);
    vecs[1]  = mk(0, 1, 8'h5A, 1, 1, 8'hC3, 1, 1, 8'hC3, 0);
    vecs[2]  = mk(0, 1, 8'h11, 0, 1, 8'h33, 1, 0, 8'h11, 1);
    vecs[3]  = mk(0, 1, 8'h22, 1, 1, 8'h33, 1, 0, 8'h22, 0);
    vecs[4]  = mk(0, 1, 8'h44, 1, 1, 8'h33, 1, 1, 8'h33, 0);
    vecs[5]  = mk(0, 0, 8'h00, 1, 1, 8'h80, 0, 1, 8'h80, 1);
    vecs[6]  = mk(0, 1, 8'h01, 1, 1, 8'h7E, 1, 1, 8'h7E, 0);
    vecs[7]  = mk(0, 1, 8'h00, 1, 1, 8'hFF, 1, 0, 8'h00, 0);
    vecs[8]  = mk(0, 1, 8'hE7, 1, 1, 8'h18, 1, 1, 8'h18, 0);
    vecs[9]  = mk(1, 1, 8'hAA, 1, 1, 8'h55, 1, 0, 8'hAA, 0);
    vecs[10] = mk(0, 1, 8'hBB, 1, 1, 8'h55, 1, 1, 8'h55, 0);
    vecs[11] = mk(0, 1, 8'hCC, 1, 1, 8'h66, 1, 0, 8'hCC, 0);

    for (int n = 0; n < 12; n++) begin
      apply_stimulus(vecs[n], n, w);
    end

    // Reset in the middle of data bit 3 while req1 holds a packet lock and ptr is 1.
    v = mk(1, 1, 8'hA5, 1, 0, 8'h00, 0, 0, 8'hA5, 0);
    apply_stimulus(v, 20, w);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hFF; bus.req1_last = 1'b0;
    #1;
    check_output("mr_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) bus.req1_valid = 1'b0;
    end
    check_output("mr_bit3_busy", {bus.txd, bus.busy, bus.owner}, 3'b111);
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h3C; bus.req0_last = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h5C; bus.req1_last = 1'b1;
    #1;
    check_output("mr_ready_in_reset", {bus.req1_ready, bus.req0_ready}, 2'b00);
    @(negedge clk);
    check_output("mr_after_reset", {bus.txd, bus.busy, bus.owner}, 3'b100);
    #1;
    check_output("mr_ready_in_reset2", {bus.req1_ready, bus.req0_ready}, 2'b00);
    rst = 1'b0;
    v = mk(0, 1, 8'h3C, 1, 1, 8'h5C, 1, 0, 8'h3C, 0);
    apply_stimulus(v, 21, w);
    check_output("mr_first_accept_wait", w, 0);

    // Owner drops valid mid-packet: the other requester must stay blocked.
    v = mk(0, 1, 8'h01, 0, 0, 8'h00, 0, 0, 8'h01, 1);
    apply_stimulus(v, 30, w);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h77; bus.req1_last = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req1_ready || !bus.busy) bad++;
    end
    check_output("locked_idle", bad, 0);
    v = mk(0, 1, 8'h02, 1, 1, 8'h77, 1, 0, 8'h02, 0);
    apply_stimulus(v, 31, w);
    v = mk(0, 0, 8'h00, 1, 1, 8'h77, 1, 1, 8'h77, 0);
    apply_stimulus(v, 32, w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
